// File: rtl/immediate_generator_if.sv
// ============================================================================
// Module   : immediate_generator_if
// Brief    : Instruction-in / decoded-immediate-out bundle for immediate_generator
// Revision : 1.0
// ============================================================================
`default_nettype none

interface immediate_generator_if;
  logic        in_valid;
  logic [31:0] instruction;
  logic        out_valid;
  logic [31:0] immediate;
  logic [2:0]  imm_fmt;
  logic        illegal;

  modport master (
    output in_valid, instruction,
    input  out_valid, immediate, imm_fmt, illegal
  );

  modport slave (
    input  in_valid, instruction,
    output out_valid, immediate, imm_fmt, illegal
  );
endinterface

`default_nettype wire

// File: rtl/immediate_generator.sv
// ============================================================================
// Module   : immediate_generator
// Brief    : Registered RV32I immediate extraction / sign-extension stage.
//            Optional macro IMMGEN_SHAMT_EN: zero-extended shamt for shift-imm.
// Revision : 1.0
// ============================================================================
`default_nettype none

module immediate_generator #(
  parameter int XLEN = 32
) (
  input  wire                    clk,
  input  wire                    rst,
  immediate_generator_if.slave   bus
);

  localparam logic [6:0] C_OP_IMM    = 7'b0010011;
  localparam logic [6:0] C_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] C_OP_JALR   = 7'b1100111;
  localparam logic [6:0] C_OP_FENCE  = 7'b0001111;
  localparam logic [6:0] C_OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] C_OP_STORE  = 7'b0100011;
  localparam logic [6:0] C_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] C_OP_LUI    = 7'b0110111;
  localparam logic [6:0] C_OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] C_OP_JAL    = 7'b1101111;
  localparam logic [6:0] C_OP_REG    = 7'b0110011;

  localparam logic [2:0] C_FMT_R = 3'd0;
  localparam logic [2:0] C_FMT_I = 3'd1;
  localparam logic [2:0] C_FMT_S = 3'd2;
  localparam logic [2:0] C_FMT_B = 3'd3;
  localparam logic [2:0] C_FMT_U = 3'd4;
  localparam logic [2:0] C_FMT_J = 3'd5;

  logic            valid_q, valid_d;
  logic [XLEN-1:0] imm_q,   imm_d;
  logic [2:0]      fmt_q,   fmt_d;
  logic            illegal_q, illegal_d;

  logic [31:0] w_ins;
  logic [6:0]  w_opcode;
  logic        w_s;

  assign w_ins    = bus.instruction;
  assign w_opcode = w_ins[6:0];
  assign w_s      = w_ins[31];

`ifdef IMMGEN_SHAMT_EN
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;
  assign w_funct3 = w_ins[14:12];
  assign w_funct7 = w_ins[31:25];
`endif

  always_comb begin
    valid_d   = bus.in_valid;
    imm_d     = imm_q;
    fmt_d     = fmt_q;
    illegal_d = illegal_q;
    if (bus.in_valid) begin
      imm_d     = '0;
      fmt_d     = C_FMT_R;
      illegal_d = 1'b0;
      case (w_opcode)
        C_OP_IMM: begin
          imm_d = {{20{w_s}}, w_ins[31:20]};
          fmt_d = C_FMT_I;
`ifdef IMMGEN_SHAMT_EN
          // Shift-immediates carry a 5-bit shamt; the upper field selects SRLI/SRAI.
          if (w_funct3 == 3'b001 || w_funct3 == 3'b101) begin
            imm_d = {27'b0, w_ins[24:20]};
            if (w_funct3 == 3'b001 && w_funct7 != 7'b0000000)
              illegal_d = 1'b1;
            if (w_funct3 == 3'b101 && w_funct7 != 7'b0000000 && w_funct7 != 7'b0100000)
              illegal_d = 1'b1;
          end
`endif
        end
        C_OP_LOAD, C_OP_JALR, C_OP_FENCE, C_OP_SYSTEM: begin
          imm_d = {{20{w_s}}, w_ins[31:20]};
          fmt_d = C_FMT_I;
        end
        C_OP_STORE: begin
          imm_d = {{20{w_s}}, w_ins[31:25], w_ins[11:7]};
          fmt_d = C_FMT_S;
        end
        C_OP_BRANCH: begin
          imm_d = {{19{w_s}}, w_ins[31], w_ins[7], w_ins[30:25], w_ins[11:8], 1'b0};
          fmt_d = C_FMT_B;
        end
        C_OP_LUI, C_OP_AUIPC: begin
          imm_d = {w_ins[31:12], 12'b0};
          fmt_d = C_FMT_U;
        end
        C_OP_JAL: begin
          imm_d = {{11{w_s}}, w_ins[31], w_ins[19:12], w_ins[20], w_ins[30:21], 1'b0};
          fmt_d = C_FMT_J;
        end
        C_OP_REG: begin
          fmt_d = C_FMT_R;
        end
        default: begin
          illegal_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      imm_q     <= '0;
      fmt_q     <= C_FMT_R;
      illegal_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      imm_q     <= imm_d;
      fmt_q     <= fmt_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.immediate = imm_q;
  assign bus.imm_fmt   = fmt_q;
  assign bus.illegal   = illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_immediate_generator.sv
// ============================================================================
// Module   : tb_immediate_generator
// Brief    : Self-checking bench for immediate_generator (reference model + literals)
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_immediate_generator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  immediate_generator_if bus ();

  immediate_generator #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } dec_t;

  function automatic longint sext(input longint v, input int bits);
    if (v >= (longint'(1) << (bits - 1))) return v - (longint'(1) << bits);
    return v;
  endfunction

  // Reference decode built from field arithmetic rather than bit concatenation.
  function automatic dec_t model_f(input logic [31:0] ins);
    dec_t   r;
    longint u;
    longint v;
    int     op;
    int     f3;
    int     f7;
    u  = longint'(ins);
    op = int'(u % 128);
    f3 = int'((u / 4096) % 8);
    f7 = int'(u / (longint'(1) << 25));
    r  = '0;
    case (op)
      'h13, 'h03, 'h67, 'h0F, 'h73: begin
        v = sext(u / (longint'(1) << 20), 12);
        r.fmt = 3'd1;
`ifdef IMMGEN_SHAMT_EN
        if (op == 'h13 && (f3 == 1 || f3 == 5)) begin
          v = (u / (longint'(1) << 20)) % 32;
          r.ill = (f3 == 1 && f7 != 0) || (f3 == 5 && f7 != 0 && f7 != 32);
        end
`else
        if (f3 == 99 && f7 == 999) r.ill = 1'b1;
`endif
        r.imm = 32'(v);
      end
      'h23: begin
        v = sext((u / (longint'(1) << 25)) * 32 + (u / 128) % 32, 12);
        r.imm = 32'(v); r.fmt = 3'd2;
      end
      'h63: begin
        v = ((u >> 31) & 1) * 4096 + ((u >> 7) & 1) * 2048
          + ((u >> 25) & 63) * 32 + ((u >> 8) & 15) * 2;
        r.imm = 32'(sext(v, 13)); r.fmt = 3'd3;
      end
      'h37, 'h17: begin
        r.imm = 32'((u / 4096) * 4096); r.fmt = 3'd4;
      end
      'h6F: begin
        v = ((u >> 31) & 1) * (longint'(1) << 20) + ((u >> 12) & 255) * 4096
          + ((u >> 20) & 1) * 2048 + ((u >> 21) & 1023) * 2;
        r.imm = 32'(sext(v, 21)); r.fmt = 3'd5;
      end
      'h33: r = '0;
      default: r.ill = 1'b1;
    endcase
    return r;
  endfunction

  dec_t        dec_now;
  logic        m_valid = 1'b0;
  dec_t        m_out   = '0;
  logic        model_ready = 1'b0;

  assign dec_now = model_f(bus.instruction);

  always @(posedge clk) begin
    if (rst) begin
      m_valid     <= 1'b0;
      m_out       <= '0;
      model_ready <= 1'b1;
    end else begin
      m_valid <= bus.in_valid;
      if (bus.in_valid) m_out <= dec_now;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (model_ready) begin
      chk("model.out_valid", 32'(bus.out_valid), 32'(m_valid));
      chk("model.immediate", bus.immediate, m_out.imm);
      chk("model.imm_fmt",   32'(bus.imm_fmt), 32'(m_out.fmt));
      chk("model.illegal",   32'(bus.illegal), 32'(m_out.ill));
    end
  end

  task automatic apply(input string name, input logic [31:0] ins,
                       input logic [31:0] eimm, input logic [2:0] efmt, input logic eill);
    @(negedge clk);
    bus.in_valid    = 1'b1;
    bus.instruction = ins;
    @(posedge clk);
    #1;
    chk({name, ".valid"}, 32'(bus.out_valid), 32'd1);
    chk({name, ".imm"},   bus.immediate, eimm);
    chk({name, ".fmt"},   32'(bus.imm_fmt), 32'(efmt));
    chk({name, ".ill"},   32'(bus.illegal), 32'(eill));
  endtask

  initial begin
    bus.in_valid    = 1'b1;
    bus.instruction = 32'hFFF00013;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.valid", 32'(bus.out_valid), 32'd0);
    chk("reset.imm",   bus.immediate, 32'd0);
    chk("reset.fmt",   32'(bus.imm_fmt), 32'd0);
    chk("reset.ill",   32'(bus.illegal), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("release.imm", bus.immediate, 32'hFFFFFFFF);

    apply("addi0",  32'h00000013, 32'h00000000, 3'd1, 1'b0);
    apply("addi-1", 32'hFFF00013, 32'hFFFFFFFF, 3'd1, 1'b0);
    apply("lw",     32'h00402003, 32'h00000004, 3'd1, 1'b0);
    apply("jalr",   32'h00500067, 32'h00000005, 3'd1, 1'b0);
    apply("sw",     32'h001121A3, 32'h00000003, 3'd2, 1'b0);
    apply("beq+",   32'h001100E3, 32'h00000800, 3'd3, 1'b0);
    apply("beq-",   32'hFE000FE3, 32'hFFFFFFFE, 3'd3, 1'b0);
    apply("lui",    32'h12345037, 32'h12345000, 3'd4, 1'b0);
    apply("auipc",  32'h00000017, 32'h00000000, 3'd4, 1'b0);
    apply("jal+",   32'h0000106F, 32'h00001000, 3'd5, 1'b0);
    apply("jal-",   32'h8000006F, 32'hFFF00000, 3'd5, 1'b0);

    // Hold: new instruction without in_valid leaves the JAL result in place.
    @(negedge clk);
    bus.in_valid    = 1'b0;
    bus.instruction = 32'h12345037;
    @(posedge clk);
    #1;
    chk("hold.valid", 32'(bus.out_valid), 32'd0);
    chk("hold.imm",   bus.immediate, 32'hFFF00000);
    chk("hold.fmt",   32'(bus.imm_fmt), 32'd5);

    apply("illegal7f", 32'h0000007F, 32'h00000000, 3'd0, 1'b1);
    apply("illeg_c",   32'hFFF00012, 32'h00000000, 3'd0, 1'b1);
    apply("add",       32'h00000033, 32'h00000000, 3'd0, 1'b0);

    // Back-to-back stream on consecutive cycles.
    apply("b2b0", 32'h00700013, 32'h00000007, 3'd1, 1'b0);
    apply("b2b1", 32'hFFE00023, 32'hFFFFFFE0, 3'd2, 1'b0);
    apply("b2b2", 32'hABCDE037, 32'hABCDE000, 3'd4, 1'b0);
    apply("b2b3", 32'h7FFFF06F, 32'h000FFFFE, 3'd5, 1'b0);

`ifdef IMMGEN_SHAMT_EN
    apply("srai",     32'h40305013, 32'h00000003, 3'd1, 1'b0);
    apply("srai_bad", 32'h20305013, 32'h00000003, 3'd1, 1'b1);
    apply("slli_bad", 32'h40301013, 32'h00000003, 3'd1, 1'b1);
`else
    apply("srai",     32'h40305013, 32'h00000403, 3'd1, 1'b0);
    apply("srai2",    32'h20305013, 32'h00000203, 3'd1, 1'b0);
`endif

    // Randomized traffic, mostly legal opcodes, occasional reset.
    for (int i = 0; i < 400; i++) begin
      logic [6:0] ops [12];
      logic [31:0] w;
      ops = '{7'h13, 7'h03, 7'h67, 7'h0F, 7'h73, 7'h23, 7'h63,
              7'h37, 7'h17, 7'h6F, 7'h33, 7'h13};
      @(negedge clk);
      w = $urandom;
      if ($urandom_range(0, 7) != 0) w[6:0] = ops[$urandom_range(0, 11)];
      if ($urandom_range(0, 3) == 0) w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
      bus.instruction = w;
      bus.in_valid    = ($urandom_range(0, 3) != 0);
      rst             = ($urandom_range(0, 49) == 0);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
